// File: rtl/activation_backward.sv
// Backward activation stage: dL/dz = dL/dy * f'(z), two-stage valid/ready
// pipeline with a per-vector last-beat marker on the output side.
module activation_backward #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int VEC_LEN    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            activ_type_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] z_i,
  input  logic [DATA_WIDTH-1:0] grad_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] grad_o,
  output logic                  out_last_o
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

  // z compared in a 2-bit-wider signed domain so that 2*ONE never overflows,
  // even at the top of the legal FRAC_BITS range.
  localparam logic signed [DATA_WIDTH+1:0] ONE_X = {{(DATA_WIDTH+1){1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic signed [DATA_WIDTH+1:0] TWO_X = ONE_X <<< 1;

  typedef enum logic [1:0] {ACT_RELU = 2'd0, ACT_SIGM = 2'd1, ACT_TANH = 2'd2, ACT_IDENT = 2'd3} act_e;

  // f'(z) only ever takes the values 0, ONE/4 or ONE, so it is carried as a
  // code and the Q-format product reduces to select / arithmetic shift:
  //   (g*ONE)>>>F = g,  (g*(ONE>>2))>>>F = g>>>2 (floor),  (g*0)>>>F = 0.
  typedef enum logic [1:0] {D_ZERO = 2'd0, D_QUART = 2'd1, D_ONE = 2'd2} dcode_e;

  logic signed [DATA_WIDTH+1:0] w_z_x;
  dcode_e                       w_dcode;
  logic                         w_advance;
  logic signed [DATA_WIDTH-1:0] w_s1_result;

  logic                         r_s1_valid;
  dcode_e                       r_s1_dcode;
  logic signed [DATA_WIDTH-1:0] r_s1_grad;
  logic                         r_s2_valid;
  logic [DATA_WIDTH-1:0]        r_grad_o;
  logic [CW-1:0]                r_cnt;

  assign w_z_x = {{2{z_i[DATA_WIDTH-1]}}, z_i};

  // Derivative selection with strict signed comparisons (z = most-negative is fine).
  always_comb begin
    w_dcode = D_ZERO;
    case (act_e'(activ_type_i))
      ACT_RELU:  w_dcode = (w_z_x > 0) ? D_ONE : D_ZERO;
      ACT_SIGM:  w_dcode = ((w_z_x > -TWO_X) && (w_z_x < TWO_X)) ? D_QUART : D_ZERO;
      ACT_TANH:  w_dcode = ((w_z_x > -ONE_X) && (w_z_x < ONE_X)) ? D_ONE : D_ZERO;
      ACT_IDENT: w_dcode = D_ONE;
      default:   w_dcode = D_ZERO;
    endcase
  end

  // Scaled gradient produced from the S1 registers, loaded into S2.
  always_comb begin
    w_s1_result = '0;
    case (r_s1_dcode)
      D_ONE:   w_s1_result = r_s1_grad;
      D_QUART: w_s1_result = r_s1_grad >>> 2;
      default: w_s1_result = '0;
    endcase
  end

  // Whole pipe moves together; an empty S2 or a ready sink lets it advance.
  assign w_advance   = !r_s2_valid || out_ready_i;
  assign in_ready_o  = w_advance;
  assign out_valid_o = r_s2_valid;
  assign grad_o      = r_grad_o;
  assign out_last_o  = r_s2_valid && (r_cnt == LAST_IDX);

  // S1: capture derivative code and upstream gradient on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_dcode <= D_ZERO;
      r_s1_grad  <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_s1_dcode <= w_dcode;
        r_s1_grad  <= $signed(grad_i);
      end
    end
  end

  // S2: output register; held while the sink stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s2_valid <= 1'b0;
      r_grad_o   <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_grad_o <= w_s1_result;
    end
  end

  // Element counter: steps on each output handshake, wraps at VEC_LEN-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_s2_valid && out_ready_i) begin
      r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_activation_backward.sv
// Directed bench for activation_backward (W=16, F=8, VEC_LEN=4, plus a VEC_LEN=1 copy).
module tb_activation_backward;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] activ = 2'd0;
  logic in_valid = 1'b0;
  logic signed [15:0] z_in = '0;
  logic signed [15:0] g_in = '0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_last;
  logic [15:0] grad_o;
  logic in_ready1, out_valid1, out_last1;
  logic [15:0] grad_o1;

  int tests = 0;
  int fails = 0;

  logic [1:0]         sa [16];
  logic signed [15:0] sz [16];
  logic signed [15:0] sg [16];
  logic [15:0]        rg [16];
  logic [15:0] rl, rl1;
  int rcnt, rstall, stall_bad, hold_bad;

  always #5 clk = ~clk;

  activation_backward #(.DATA_WIDTH(16), .FRAC_BITS(8), .VEC_LEN(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .activ_type_i(activ), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .z_i(z_in), .grad_i(g_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .grad_o(grad_o), .out_last_o(out_last));

  activation_backward #(.DATA_WIDTH(16), .FRAC_BITS(8), .VEC_LEN(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .activ_type_i(activ), .in_valid_i(in_valid),
    .in_ready_o(in_ready1), .z_i(z_in), .grad_i(g_in), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .grad_o(grad_o1), .out_last_o(out_last1));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one beat into an empty pipe; report valid one cycle after accept,
  // valid/data two cycles after accept.
  task automatic one_beat(input logic [1:0] a, input logic signed [15:0] z, input logic signed [15:0] g,
                          output logic v_early, output logic v_on, output logic [15:0] go);
    @(negedge clk);
    out_ready = 1'b1; activ = a; z_in = z; g_in = g; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    v_early = out_valid;
    @(negedge clk);
    v_on = out_valid;
    go = grad_o;
  endtask

  // Push n beats from sa/sz/sg back-to-back; after the first output, hold
  // out_ready low for stall_len cycles. Collects outputs into rg/rl/rl1.
  task automatic stream(input int n, input int stall_len);
    int sent, cyc, stall_left;
    bit prev_stall;
    logic [15:0] held;
    sent = 0; cyc = 0; stall_left = 0; prev_stall = 0; held = '0;
    rcnt = 0; rstall = 0; stall_bad = 0; hold_bad = 0; rl = '0; rl1 = '0;
    while (rcnt < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      out_ready = (stall_left == 0);
      in_valid = (sent < n);
      if (sent < n) begin activ = sa[sent]; z_in = sz[sent]; g_in = sg[sent]; end
      #1;
      if (!out_ready) begin
        rstall++;
        if (in_ready !== 1'b0) stall_bad++;
        if (prev_stall && grad_o !== held) hold_bad++;
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        rg[rcnt] = grad_o; rl[rcnt] = out_last; rl1[rcnt] = out_valid1 && out_last1;
        rcnt++;
        if (rcnt == 1) stall_left = stall_len;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      prev_stall = !out_ready;
      held = grad_o;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (grad_o !== 16'd0) begin fails++; $display("FAIL reset_grad got=%0d exp=0", grad_o); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", out_last); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_relu();
    logic signed [15:0] zv [3] = '{16'sd100, 16'sd0, -16'sd5};
    logic signed [15:0] gv [3] = '{-16'sd300, 16'sd77, 16'sd900};
    logic signed [15:0] ev [3] = '{-16'sd300, 16'sd0, 16'sd0};
    logic ve, vo; logic [15:0] go;
    for (int i = 0; i < 3; i++) begin
      one_beat(2'd0, zv[i], gv[i], ve, vo, go);
      tests++; if (ve !== 1'b0) begin fails++; $display("FAIL relu_early[%0d] valid got=%b exp=0", i, ve); end
      tests++; if (vo !== 1'b1) begin fails++; $display("FAIL relu_lat[%0d] valid got=%b exp=1", i, vo); end
      tests++; if (go !== ev[i]) begin fails++; $display("FAIL relu[%0d] got=%0d exp=%0d", i, $signed(go), ev[i]); end
    end
  endtask

  task automatic test_sigmoid();
    logic signed [15:0] zv [4] = '{-16'sd511, 16'sd512, 16'sd3, -16'sd512};
    logic signed [15:0] gv [4] = '{16'sd400, 16'sd400, -16'sd3, 16'sd400};
    logic signed [15:0] ev [4] = '{16'sd100, 16'sd0, -16'sd1, 16'sd0};
    logic ve, vo; logic [15:0] go;
    for (int i = 0; i < 4; i++) begin
      one_beat(2'd1, zv[i], gv[i], ve, vo, go);
      tests++; if (vo !== 1'b1 || go !== ev[i]) begin
        fails++; $display("FAIL sigmoid[%0d] got v=%b %0d exp v=1 %0d", i, vo, $signed(go), ev[i]); end
    end
  endtask

  task automatic test_tanh_identity();
    logic [1:0]         av [4] = '{2'd2, 2'd2, 2'd3, 2'd2};
    logic signed [15:0] zv [4] = '{16'sd255, -16'sd256, -16'sd32768, -16'sd255};
    logic signed [15:0] gv [4] = '{16'sd32767, 16'sd5, -16'sd32768, -16'sd9};
    logic signed [15:0] ev [4] = '{16'sd32767, 16'sd0, -16'sd32768, -16'sd9};
    logic ve, vo; logic [15:0] go;
    for (int i = 0; i < 4; i++) begin
      one_beat(av[i], zv[i], gv[i], ve, vo, go);
      tests++; if (vo !== 1'b1 || go !== ev[i]) begin
        fails++; $display("FAIL tanh_id[%0d] got v=%b %0d exp v=1 %0d", i, vo, $signed(go), ev[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) begin sa[i] = 2'd3; sz[i] = 16'(i * 13 - 40); sg[i] = 16'(1000 + i * 7); end
    stream(6, 5);
    tests++; if (rcnt !== 6) begin fails++; $display("FAIL bp_count got=%0d exp=6", rcnt); end
    for (int i = 0; i < 6; i++) begin
      tests++; if (rg[i] !== 16'(1000 + i * 7)) begin
        fails++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, $signed(rg[i]), 1000 + i * 7); end
    end
    tests++; if (rstall !== 5) begin fails++; $display("FAIL bp_stall_cycles got=%0d exp=5", rstall); end
    tests++; if (stall_bad !== 0) begin fails++; $display("FAIL bp_in_ready_high_in_stall got=%0d exp=0", stall_bad); end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_grad_hold got=%0d exp=0", hold_bad); end
    tests++; if (rl[5:0] !== 6'b001000) begin fails++; $display("FAIL bp_last got=%b exp=001000", rl[5:0]); end
  endtask

  task automatic test_last_wrap();
    do_reset();
    for (int i = 0; i < 12; i++) begin sa[i] = 2'd0; sz[i] = 16'sd1; sg[i] = 16'(i + 1); end
    stream(10, 0);
    tests++; if (rcnt !== 10) begin fails++; $display("FAIL wrap_count got=%0d exp=10", rcnt); end
    tests++; if (rl[9:0] !== 10'b0010001000) begin fails++; $display("FAIL wrap_last got=%b exp=0010001000", rl[9:0]); end
    tests++; if (rl1[9:0] !== 10'h3FF) begin fails++; $display("FAIL vec1_last got=%b exp=1111111111", rl1[9:0]); end
    tests++; if (rg[9] !== 16'd10) begin fails++; $display("FAIL wrap_data9 got=%0d exp=10", rg[9]); end
    // counter sits at 2: the second of the next two beats closes the vector
    stream(2, 0);
    tests++; if (rl[1:0] !== 2'b10) begin fails++; $display("FAIL wrap_cnt2_last got=%b exp=10", rl[1:0]); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 4; i++) begin sa[i] = 2'd3; sz[i] = '0; sg[i] = 16'(50 + i); end
    stream(2, 0);
    @(negedge clk);
    out_ready = 1'b0; activ = 2'd3; g_in = 16'sd111; in_valid = 1'b1;
    @(negedge clk);
    g_in = 16'sd222;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL mid_rst_last got=%b exp=0", out_last); end
    tests++; if (grad_o !== 16'd0) begin fails++; $display("FAIL mid_rst_grad got=%0d exp=0", grad_o); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stream(4, 0);
    tests++; if (rcnt !== 4) begin fails++; $display("FAIL mid_after_count got=%0d exp=4", rcnt); end
    tests++; if (rl[3:0] !== 4'b1000) begin fails++; $display("FAIL mid_after_last got=%b exp=1000", rl[3:0]); end
    tests++; if (rg[0] !== 16'd50) begin fails++; $display("FAIL mid_after_first got=%0d exp=50", rg[0]); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_relu();
    test_sigmoid();
    test_tanh_identity();
    test_backpressure();
    test_last_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
